// File: rtl/ex_mdu_pkg.sv
// Shared operation/result-class codes and divider state encoding for the execute stage.
package ex_mdu_pkg;

    localparam logic [7:0] EXE_OP_NOP   = 8'h00;
    localparam logic [7:0] EXE_OP_AND   = 8'h24;
    localparam logic [7:0] EXE_OP_OR    = 8'h25;
    localparam logic [7:0] EXE_OP_XOR   = 8'h26;
    localparam logic [7:0] EXE_OP_NOR   = 8'h27;
    localparam logic [7:0] EXE_OP_SLL   = 8'h7C;
    localparam logic [7:0] EXE_OP_SRL   = 8'h02;
    localparam logic [7:0] EXE_OP_SRA   = 8'h03;
    localparam logic [7:0] EXE_OP_SLT   = 8'h2A;
    localparam logic [7:0] EXE_OP_SLTU  = 8'h2B;
    localparam logic [7:0] EXE_OP_ADD   = 8'h20;
    localparam logic [7:0] EXE_OP_ADDU  = 8'h21;
    localparam logic [7:0] EXE_OP_SUB   = 8'h22;
    localparam logic [7:0] EXE_OP_SUBU  = 8'h23;
    localparam logic [7:0] EXE_OP_MULT  = 8'h18;
    localparam logic [7:0] EXE_OP_MULTU = 8'h19;
    localparam logic [7:0] EXE_OP_DIV   = 8'h1A;
    localparam logic [7:0] EXE_OP_DIVU  = 8'h1B;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ex_mdu_div_unit.sv
// Iterative restoring radix-2 divider; magnitudes are divided, signs fixed up on output.
//   state | meaning
//   IDLE  | waiting for start; latches operands
//   BUSY  | one quotient bit per cycle, DATA_W cycles
//   DONE  | result valid for one cycle
module div_unit
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_W);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q, quo_q, dvsr_q;
    logic              neg_quo, neg_rem;
    logic [DATA_W:0]   shifted, diff;
    logic              zero_dvsr, last_bit;

    assign zero_dvsr = (op2 == '0);
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
    assign shifted   = {rem_q, quo_q[DATA_W-1]};
    assign diff      = shifted - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state <= DIV_IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (annul) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start) state_nxt = zero_dvsr ? DIV_DONE : DIV_BUSY;
                DIV_BUSY: if (last_bit) state_nxt = DIV_DONE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        ready     = (state == DIV_DONE);
        quotient  = neg_quo ? -quo_q : quo_q;
        remainder = neg_rem ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == DIV_IDLE && start && !annul) begin
            cnt   <= '0;
            rem_q <= '0;
            if (zero_dvsr) begin
                quo_q   <= '0;
                dvsr_q  <= '0;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end else begin
                // the most negative dividend negates to itself, which is its correct unsigned magnitude
                quo_q   <= (sign_op && op1[DATA_W-1]) ? -op1 : op1;
                dvsr_q  <= (sign_op && op2[DATA_W-1]) ? -op2 : op2;
                neg_quo <= sign_op && (op1[DATA_W-1] ^ op2[DATA_W-1]);
                neg_rem <= sign_op && op1[DATA_W-1];
            end
        end else if (state == DIV_BUSY) begin
            cnt   <= cnt + 1'b1;
            rem_q <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// MIPS execute stage: combinational logic/shift/arith/multiply plus an iterative divider
// that holds the pipeline through stallreq_o until its result is ready.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  we_i,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   logic_res, shift_res, arith_res;
    logic                is_mult, is_mult_s, is_div;
    logic [2*DATA_W-1:0] mul_a, mul_b, prod;
    logic                div_ready;
    logic [DATA_W-1:0]   div_quo, div_rem;

    assign shamt     = reg1_i[SH_W-1:0];
    assign is_mult_s = (aluop_i == EXE_OP_MULT);
    assign is_mult   = is_mult_s || (aluop_i == EXE_OP_MULTU);
    assign is_div    = (aluop_i == EXE_OP_DIV) || (aluop_i == EXE_OP_DIVU);

    // extending to full product width keeps the low 2*DATA_W bits exact for both signednesses
    assign mul_a = {{DATA_W{is_mult_s & reg1_i[DATA_W-1]}}, reg1_i};
    assign mul_b = {{DATA_W{is_mult_s & reg2_i[DATA_W-1]}}, reg2_i};
    assign prod  = mul_a * mul_b;

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OP_OR:  logic_res = reg1_i | reg2_i;
            EXE_OP_AND: logic_res = reg1_i & reg2_i;
            EXE_OP_XOR: logic_res = reg1_i ^ reg2_i;
            EXE_OP_NOR: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_OP_SLL: shift_res = reg2_i << shamt;
            EXE_OP_SRL: shift_res = reg2_i >> shamt;
            EXE_OP_SRA: shift_res = $signed(reg2_i) >>> shamt;
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            EXE_OP_ADD, EXE_OP_ADDU: arith_res = reg1_i + reg2_i;
            EXE_OP_SUB, EXE_OP_SUBU: arith_res = reg1_i - reg2_i;
            EXE_OP_SLT:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_OP_SLTU: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:     arith_res = '0;
        endcase
    end

    div_unit #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div && !flush_i),
        .sign_op   (aluop_i == EXE_OP_DIV),
        .annul     (flush_i),
        .op1       (reg1_i),
        .op2       (reg2_i),
        .ready     (div_ready),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        waddr_o    = '0;
        we_o       = 1'b0;
        wdata_o    = '0;
        hi_o       = '0;
        lo_o       = '0;
        whilo_o    = 1'b0;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            waddr_o = waddr_i;
            we_o    = we_i && !is_mult && !is_div;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_ARITH: wdata_o = arith_res;
                default:       wdata_o = '0;
            endcase
            if (is_mult && !flush_i) begin
                whilo_o = 1'b1;
                hi_o    = prod[2*DATA_W-1:DATA_W];
                lo_o    = prod[DATA_W-1:0];
            end else if (is_div && div_ready && !flush_i) begin
                whilo_o = 1'b1;
                hi_o    = div_rem;
                lo_o    = div_quo;
            end
            stallreq_o = is_div && !div_ready && !flush_i;
        end
    end

endmodule
